pwm_gate_monitor: RTL and testbench

PWM_GATE_MONITOR -- requirements
Module: pwm_gate_monitor

---
 rtl/pwm_gate_monitor.sv | 132 +++++++++++++
 tb/tb_pwm_gate_monitor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gate_monitor.sv
// PWM gate monitor: synchronizes the high/low gate drives, measures the gate_hi period,
// high time and dead time, flags stalled PWM and latches shoot-through faults.
module pwm_gate_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FAULT_CYC   = 2
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             gate_hi,
    input  logic             gate_lo,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] dead_time,
    output logic             meas_valid,
    output logic             stalled,
    output logic             fault,
    output logic             state_dbg
);

    // meas_valid is a one-cycle pulse with no ready: consumers must take period,
    // high_time and dead_time in that cycle; the values then hold until the next pulse.

    localparam int OV_W = $clog2(FAULT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [OV_W-1:0]  OV_LIM  = OV_W'(FAULT_CYC);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] hs_sync;
    logic [SYNC_STAGES-1:0] ls_sync;
    logic                   hs;
    logic                   ls;
    logic                   hs_d;
    logic                   rise;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_acc;
    logic [CNT_W-1:0]       dead_acc;
    logic [OV_W-1:0]        ov_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
    endfunction

    assign hs        = hs_sync[SYNC_STAGES-1];
    assign ls        = ls_sync[SYNC_STAGES-1];
    assign rise      = hs & ~hs_d;
    assign state_dbg = (state == MEAS);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            hs_sync <= '0;
            ls_sync <= '0;
            hs_d    <= 1'b0;
        end else begin
            hs_sync <= {hs_sync[SYNC_STAGES-2:0], gate_hi};
            ls_sync <= {ls_sync[SYNC_STAGES-2:0], gate_lo};
            hs_d    <= hs;
        end
    end

    // Shoot-through: fault is raised from the registered run length, so it lands one
    // cycle after the run reaches FAULT_CYC; a coinciding clear loses to the set.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ov_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            if (hs && ls) begin
                if (ov_cnt != OV_LIM) ov_cnt <= ov_cnt + OV_W'(1);
            end else begin
                ov_cnt <= '0;
            end
            if (ov_cnt == OV_LIM) fault <= 1'b1;
            else if (fault_clr)   fault <= 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_acc     <= '0;
            dead_acc   <= '0;
            period     <= '0;
            high_time  <= '0;
            dead_time  <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= MEAS;
                        per_cnt  <= CNT_ONE;
                        hi_acc   <= CNT_ONE;
                        dead_acc <= '0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period     <= per_cnt;
                        high_time  <= hi_acc;
                        dead_time  <= dead_acc;
                        meas_valid <= 1'b1;
                        stalled    <= 1'b0;
                        per_cnt    <= CNT_ONE;
                        hi_acc     <= CNT_ONE;
                        dead_acc   <= '0;
                    end else if (per_cnt == CNT_MAX) begin
                        // No edge for a full counter span: give up and wait to re-arm.
                        stalled <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        per_cnt  <= sat_inc(per_cnt, 1'b1);
                        hi_acc   <= sat_inc(hi_acc, hs);
                        dead_acc <= sat_inc(dead_acc, ~hs & ~ls);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gate_monitor.sv
// Randomized and directed bench for pwm_gate_monitor against an index-based reference model.
`timescale 1ns/1ps
module tb_pwm_gate_monitor;

    localparam int CW   = 8;
    localparam int S    = 2;
    localparam int F    = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          gate_hi;
    logic          gate_lo;
    logic          fault_clr;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic [CW-1:0] dead_time;
    logic          meas_valid;
    logic          stalled;
    logic          fault;
    logic          state_dbg;

    int errors = 0;
    int checks = 0;
    int mv_count = 0;
    int base;
    bit rand_clr = 0;

    pwm_gate_monitor #(.CNT_W(CW), .SYNC_STAGES(S), .FAULT_CYC(F)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .fault_clr (fault_clr),
        .period    (period),
        .high_time (high_time),
        .dead_time (dead_time),
        .meas_valid(meas_valid),
        .stalled   (stalled),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: processes each synchronized sample by index
    bit dl_h[0:S];
    bit dl_l[0:S];
    bit ov_q[$];
    bit hist_h[$];
    bit hist_l[$];
    bit armed;
    int rise_idx;
    int m_period, m_high, m_dead;
    bit m_mv, m_stalled, m_fault;
    bit mh, mhd, ml, mrise, mcond;
    int idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= S; i++) begin
                dl_h[i] = 1'b0;
                dl_l[i] = 1'b0;
            end
            ov_q.delete();
            for (int i = 0; i < F; i++) ov_q.push_back(1'b0);
            hist_h.delete();
            hist_l.delete();
            armed = 0; rise_idx = 0;
            m_period = 0; m_high = 0; m_dead = 0;
            m_mv = 0; m_stalled = 0; m_fault = 0;
        end else begin
            mh    = dl_h[S-1];
            mhd   = dl_h[S];
            ml    = dl_l[S-1];
            mrise = mh && !mhd;
            mcond = 1'b1;
            foreach (ov_q[i]) if (!ov_q[i]) mcond = 1'b0;
            if (mcond) m_fault = 1'b1;
            else if (fault_clr) m_fault = 1'b0;
            void'(ov_q.pop_front());
            ov_q.push_back(mh && ml);

            m_mv = 1'b0;
            idx = hist_h.size();
            if (mrise) begin
                if (armed) begin
                    m_period = idx - rise_idx;
                    m_high = 0;
                    m_dead = 0;
                    for (int j = rise_idx; j < idx; j++) begin
                        if (hist_h[j]) m_high++;
                        if (!hist_h[j] && !hist_l[j]) m_dead++;
                    end
                    m_mv = 1'b1;
                    m_stalled = 1'b0;
                end
                armed = 1;
                rise_idx = idx;
            end else if (armed && (idx - rise_idx) == MAXC) begin
                armed = 0;
                m_stalled = 1'b1;
            end
            hist_h.push_back(mh);
            hist_l.push_back(ml);
            for (int i = S; i > 0; i--) begin
                dl_h[i] = dl_h[i-1];
                dl_l[i] = dl_l[i-1];
            end
            dl_h[0] = gate_hi;
            dl_l[0] = gate_lo;
        end
    end

    // scoreboard: every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_period", period, m_period);
            chk("cyc_high_time", high_time, m_high);
            chk("cyc_dead_time", dead_time, m_dead);
            chk("cyc_meas_valid", meas_valid, m_mv);
            chk("cyc_stalled", stalled, m_stalled);
            chk("cyc_fault", fault, m_fault);
            if (meas_valid) mv_count++;
        end
    end

    // driver tasks (called at a negedge)
    task automatic seg(input bit h, input bit l, input int n);
        for (int i = 0; i < n; i++) begin
            gate_hi   = h;
            gate_lo   = l;
            fault_clr = rand_clr && ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        fault_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gate_hi = 1'b0;
        gate_lo = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high_time"}, high_time, 0);
        chk({tag, "_dead_time"}, dead_time, 0);
        chk({tag, "_meas_valid"}, meas_valid, 0);
        chk({tag, "_stalled"}, stalled, 0);
        chk({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        gate_hi = 1'b0;
        gate_lo = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // first edge after reset only arms; the second gives period 100
        seg(0, 0, 5);
        seg(1, 0, 50);
        seg(0, 0, 50);
        #1;
        chk("first_rise_no_valid", mv_count, 0);
        chk("first_rise_period", period, 0);
        chk("armed_state", state_dbg, 1);
        seg(1, 0, 10);
        seg(0, 0, 10);
        #1;
        chk("second_rise_valid", mv_count, 1);
        chk("second_rise_period", period, 100);
        chk("second_rise_high", high_time, 50);
        chk("second_rise_dead", dead_time, 50);

        // steady PWM 40 / 4 / 32 / 4
        do_reset();
        base = mv_count;
        repeat (5) begin
            seg(1, 0, 40);
            seg(0, 0, 4);
            seg(0, 1, 32);
            seg(0, 0, 4);
        end
        seg(1, 0, 40);
        seg(0, 0, 4);
        #1;
        chk("steady_valid_count", mv_count - base, 5);
        chk("steady_period", period, 80);
        chk("steady_high", high_time, 40);
        chk("steady_dead", dead_time, 8);

        // asynchronous reset mid-period, then re-arm only
        seg(0, 1, 10);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = mv_count;
        seg(0, 1, 12);
        seg(0, 0, 4);
        seg(1, 0, 40);
        seg(0, 0, 10);
        #1 chk("rearm_no_valid", mv_count - base, 0);

        // stall after a valid measurement
        seg(0, 0, 30);
        seg(1, 0, 20);
        seg(0, 0, 300);
        #1;
        chk("stall_flag", stalled, 1);
        chk("stall_state_idle", state_dbg, 0);
        chk("stall_hold_period", period, 80);
        chk("stall_hold_high", high_time, 40);
        chk("stall_hold_dead", dead_time, 40);
        seg(1, 0, 10);
        seg(0, 0, 40);
        #1 chk("stall_after_one_rise", stalled, 1);
        seg(1, 0, 10);
        seg(0, 0, 8);
        #1;
        chk("stall_cleared", stalled, 0);
        chk("post_stall_period", period, 50);
        chk("post_stall_high", high_time, 10);
        chk("post_stall_dead", dead_time, 40);

        // runt pulse
        do_reset();
        seg(0, 0, 5);
        repeat (4) begin
            seg(1, 0, 1);
            seg(0, 0, 9);
        end
        seg(1, 0, 1);
        seg(0, 0, 6);
        #1;
        chk("runt_period", period, 10);
        chk("runt_high", high_time, 1);
        chk("runt_dead", dead_time, 9);

        // shoot-through
        do_reset();
        seg(0, 0, 5);
        seg(1, 1, 1);
        seg(0, 0, 8);
        #1 chk("overlap_1_no_fault", fault, 0);
        seg(1, 1, 2);
        seg(0, 0, 8);
        #1 chk("overlap_2_fault", fault, 1);
        seg(1, 1, 5);
        gate_hi = 1'b1;
        gate_lo = 1'b1;
        pulse_clr();
        seg(1, 1, 3);
        #1 chk("clr_during_overlap", fault, 1);
        seg(0, 0, 6);
        pulse_clr();
        #1 chk("clr_after_overlap", fault, 0);

        // randomized PWM with occasional overlap, stalls and clears
        do_reset();
        rand_clr = 1;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0) seg(1, 1, $urandom_range(1, 3));
            seg(1, 0, $urandom_range(1, 30));
            seg(0, 0, $urandom_range(0, 4));
            seg(0, 1, $urandom_range(0, 30));
            seg(0, 0, $urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) seg(0, 0, 260);
        end
        rand_clr = 0;
        seg(0, 0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
